// File: rtl/ram_pipelined_if.sv
// ram_pipelined_if: read/write bus between the load/store unit (master)
// and the pipelined data RAM (slave).
interface ram_pipelined_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_err;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_err;

  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_be, wr_data,
    input  rd_data, rd_valid, rd_err, wr_err
  );

  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_be, wr_data,
    output rd_data, rd_valid, rd_err, wr_err
  );
endinterface

// File: rtl/ram_pipelined.sv
// ram_pipelined: 1-read/1-write word RAM with a READ_LATENCY-deep read
// pipeline (valid/err/data), per-byte write enables and out-of-range flags.
// Optional macro RAM_RDW_FORWARD_EN: on a same-index read/write in one edge
// the read returns the newly written bytes (write-first per byte); without
// it the read returns the old word (read-first).
module ram_pipelined #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned ADDR_SHIFT   = 1,
  parameter int unsigned DEPTH        = 32768,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic            clk,
  input logic            rstn,
  ram_pipelined_if.slave bus
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One spare bit so DEPTH == 2**ADDR_WIDTH still fits the compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   rd_idx;
  logic [ADDR_WIDTH:0]   wr_idx;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [IW-1:0]         rd_word;
  logic [IW-1:0]         wr_word;
  logic [DATA_WIDTH-1:0] rd_word_data;

  logic                  v_q [READ_LATENCY];
  logic                  e_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] d_q [READ_LATENCY];
  logic                  wr_err_q;

  // Word index decode and range check for both ports.
  always_comb begin
    rd_idx      = {1'b0, bus.rd_addr} >> ADDR_SHIFT;
    wr_idx      = {1'b0, bus.wr_addr} >> ADDR_SHIFT;
    rd_in_range = rd_idx < DEPTH_L;
    wr_in_range = wr_idx < DEPTH_L;
    rd_word     = rd_idx[IW-1:0];
    wr_word     = wr_idx[IW-1:0];
  end

  // Array read word, optionally merged with same-edge write bytes.
  always_comb begin
    rd_word_data = mem[rd_word];
`ifdef RAM_RDW_FORWARD_EN
    if (bus.wr_en && wr_in_range && (wr_idx == rd_idx)) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) rd_word_data[8*b +: 8] = bus.wr_data[8*b +: 8];
      end
    end
`endif
  end

  // Byte-masked array write; writes during reset and out-of-range are dropped.
  always_ff @(posedge clk) begin
    if (rstn && bus.wr_en && wr_in_range) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) mem[wr_word][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  // Read pipeline: stage 0 captures the array read, later stages shift.
  // err/data only advance with a valid token so rd_data holds between results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        v_q[i] <= 1'b0;
        e_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= bus.rd_req;
      if (bus.rd_req) begin
        e_q[0] <= !rd_in_range;
        d_q[0] <= rd_in_range ? rd_word_data : '0;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          e_q[i] <= e_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end
  end

  // One-cycle flag for an out-of-range write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wr_err_q <= 1'b0;
    else       wr_err_q <= bus.wr_en && !wr_in_range;
  end

  assign bus.rd_valid = v_q[READ_LATENCY-1];
  assign bus.rd_err   = v_q[READ_LATENCY-1] & e_q[READ_LATENCY-1];
  assign bus.rd_data  = d_q[READ_LATENCY-1];
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_ram_pipelined.sv
// tb_ram_pipelined: drives three ram_pipelined instances (READ_LATENCY 1, 2
// and 4, DEPTH 1000) with identical stimulus and scores each against a
// word-array reference model through per-instance expectation queues.
module tb_ram_pipelined;

  localparam int DEPTH = 1000;
  localparam int LAT [3] = '{1, 2, 4};

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem_m [DEPTH];
  rd_exp_t     q [3][$];
  int          wq [$];
  logic [31:0] last_exp [3];

  ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) rif1 ();
  ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) rif2 ();
  ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) rif4 ();

  assign rif1.rd_req = rd_req;  assign rif1.rd_addr = rd_addr;
  assign rif1.wr_en = wr_en;    assign rif1.wr_addr = wr_addr;
  assign rif1.wr_be = wr_be;    assign rif1.wr_data = wr_data;
  assign rif2.rd_req = rd_req;  assign rif2.rd_addr = rd_addr;
  assign rif2.wr_en = wr_en;    assign rif2.wr_addr = wr_addr;
  assign rif2.wr_be = wr_be;    assign rif2.wr_data = wr_data;
  assign rif4.rd_req = rd_req;  assign rif4.rd_addr = rd_addr;
  assign rif4.wr_en = wr_en;    assign rif4.wr_addr = wr_addr;
  assign rif4.wr_be = wr_be;    assign rif4.wr_data = wr_data;

  ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ADDR_SHIFT(1),
                  .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (.clk(clk), .rstn(rstn), .bus(rif1));
  ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ADDR_SHIFT(1),
                  .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (.clk(clk), .rstn(rstn), .bus(rif2));
  ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ADDR_SHIFT(1),
                  .DEPTH(DEPTH), .READ_LATENCY(4)) dut4 (.clk(clk), .rstn(rstn), .bus(rif4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h expected=%h", nm, LAT[k], cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic v, input logic e, input logic we,
                           input logic [31:0] d, input logic wexp);
    rd_exp_t x;
    if (!rstn) begin
      chk("reset_rd_valid", k, 32'(v), 32'd0);
      chk("reset_rd_err", k, 32'(e), 32'd0);
      chk("reset_wr_err", k, 32'(we), 32'd0);
      chk("reset_rd_data", k, d, 32'd0);
    end else begin
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        x = q[k].pop_front();
        chk("rd_valid", k, 32'(v), 32'd1);
        chk("rd_err", k, 32'(e), 32'(x.err));
        chk("rd_data", k, d, x.data);
        last_exp[k] = x.data;
      end else begin
        chk("no_strobe", k, 32'(v), 32'd0);
        if (!v) chk("rd_hold", k, d, last_exp[k]);
      end
      chk("wr_err", k, 32'(we), 32'(wexp));
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  always begin
    logic wexp;
    @(posedge clk);
    cyc = cyc + 1;
    #2;
    wexp = 1'b0;
    if (rstn && wq.size() > 0 && wq[0] == cyc) begin
      wexp = 1'b1;
      void'(wq.pop_front());
    end
    check_dut(0, rif1.rd_valid, rif1.rd_err, rif1.wr_err, rif1.rd_data, wexp);
    check_dut(1, rif2.rd_valid, rif2.rd_err, rif2.wr_err, rif2.rd_data, wexp);
    check_dut(2, rif4.rd_valid, rif4.rd_err, rif4.wr_err, rif4.rd_data, wexp);
  end

  // One cycle of stimulus; the model computes the expected result.
  task automatic drive(input logic rq, input logic [15:0] ra, input logic we,
                       input logic [15:0] wa, input logic [3:0] be, input logic [31:0] wd);
    rd_exp_t x;
    int ri, wi;
    @(negedge clk);
    rstn = 1'b1;
    rd_req = rq; rd_addr = ra; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    ri = int'(ra) >> 1;
    wi = int'(wa) >> 1;
    if (rq) begin
      if (ri >= DEPTH) begin
        x.err = 1'b1;
        x.data = '0;
      end else begin
        x.err = 1'b0;
        x.data = mem_m[ri];
`ifdef RAM_RDW_FORWARD_EN
        if (we && wi == ri)
          for (int b = 0; b < 4; b++) if (be[b]) x.data[8*b +: 8] = wd[8*b +: 8];
`endif
      end
      for (int k = 0; k < 3; k++) begin
        x.due = cyc + LAT[k];
        q[k].push_back(x);
      end
    end
    if (we) begin
      if (wi >= DEPTH) wq.push_back(cyc + 1);
      else for (int b = 0; b < 4; b++) if (be[b]) mem_m[wi][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // One reset cycle with a read and a write presented; both must be ignored.
  task automatic reset_cycle(input logic [15:0] ra, input logic [15:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rstn = 1'b0;
    rd_req = 1'b1; rd_addr = ra; wr_en = 1'b1; wr_addr = wa; wr_be = 4'hF; wr_data = wd;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      last_exp[k] = '0;
    end
    wq.delete();
  endtask

  function automatic logic [15:0] a_of(input int idx, input int lsb);
    return 16'((idx << 1) | lsb);
  endfunction

  initial begin
    int ri, wi;
    logic rq, we;
    for (int k = 0; k < 3; k++) last_exp[k] = '0;
    for (int i = 0; i < 3; i++) reset_cycle(16'h0000, 16'h0000, 32'h0);

    // Fill every word so the model never depends on undefined contents.
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, a_of(i, 0), 4'hF, $urandom);

    // Write then read back.
    drive(1'b0, '0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    drive(1'b1, 16'h0010, 1'b0, '0, '0, '0);
    idle(5);

    // Byte enables.
    drive(1'b0, '0, 1'b1, 16'h0020, 4'hF, 32'h11223344);
    drive(1'b0, '0, 1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD);
    drive(1'b0, '0, 1'b1, 16'h0022, 4'h0, 32'hFFFFFFFF);
    drive(1'b1, 16'h0020, 1'b0, '0, '0, '0);
    drive(1'b1, 16'h0023, 1'b0, '0, '0, '0);
    idle(5);

    // Same-index read/write collision.
    drive(1'b0, '0, 1'b1, 16'h0030, 4'hF, 32'h00000000);
    drive(1'b1, 16'h0030, 1'b1, 16'h0030, 4'hF, 32'hFFFFFFFF);
    drive(1'b1, 16'h0030, 1'b1, 16'h0031, 4'b0110, 32'h12345678);
    drive(1'b1, 16'h0030, 1'b0, '0, '0, '0);
    idle(5);

    // Range boundary: index 999 valid, 1000 and above rejected.
    drive(1'b0, '0, 1'b1, 16'd1998, 4'hF, 32'hCAFEF00D);
    drive(1'b1, 16'd2000, 1'b1, 16'd2000, 4'hF, 32'h0BADBEEF);
    drive(1'b1, 16'd1998, 1'b0, '0, '0, '0);
    drive(1'b1, 16'd1999, 1'b1, 16'hFFFF, 4'hF, 32'h55555555);
    drive(1'b1, 16'hFFFF, 1'b0, '0, '0, '0);
    idle(6);

    // Streaming reads, then a reset with reads still in flight.
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, a_of(i, 0), 4'hF, 32'(i + 1));
    for (int i = 0; i < 8; i++) drive(1'b1, a_of(i, 0), 1'b0, '0, '0, '0);
    idle(6);
    for (int i = 0; i < 4; i++) drive(1'b1, a_of(i, 0), 1'b0, '0, '0, '0);
    reset_cycle(a_of(5, 0), a_of(0, 0), 32'hBAD0BAD0);
    idle(6);
    drive(1'b1, a_of(0, 0), 1'b0, '0, '0, '0);
    drive(1'b1, a_of(7, 1), 1'b0, '0, '0, '0);
    idle(6);

    // Randomized traffic over a small window to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) != 0);
      ri = ($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 32767)
         : (($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1)
                                         : $urandom_range(0, 31));
      wi = ($urandom_range(0, 3) == 0) ? ri
         : (($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 32767) : $urandom_range(0, 31));
      drive(rq, a_of(ri, $urandom_range(0, 1)), we, a_of(wi, $urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 499) == 0) reset_cycle(a_of(ri, 0), a_of(wi, 0), $urandom);
    end
    idle(8);

    for (int k = 0; k < 3; k++) chk("drained", k, 32'(q[k].size()), 32'd0);
    chk("wr_err_drained", 0, 32'(wq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
